// File: rtl/prbs7_parity_checker.sv
// Receive-side checker for the 8-bit PRBS7+parity stream (x^7+x^6+1, bit7 = inverted XOR of [6:0]).
// Self-synchronises on the incoming words, tracks lock, and keeps saturating parity/sequence error counts.
module prbs7_parity_checker #(
  parameter int LOCK_COUNT   = 4,
  parameter int UNLOCK_COUNT = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       din,
  input  logic             clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] parity_err_cnt,
  output logic [CNT_W-1:0] seq_err_cnt
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [3:0] LOCK_N   = 4'(LOCK_COUNT);
  localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_COUNT);

  function automatic logic [6:0] prbs_next(input logic [6:0] p);
    return {p[5:0], p[6] ^ p[5]};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  state_t     state;
  state_t     state_nxt;
  logic [6:0] prev;
  logic       have_prev;
  logic [3:0] good_run;
  logic [3:0] good_nxt;
  logic [3:0] bad_run;
  logic [3:0] bad_nxt;
  logic       err_nxt;
  logic       par_inc;
  logic       seq_inc;

  logic       vld_p0;
  logic       parity_ok_p0;
  logic       seq_ok_p0;
  logic       word_ok_p0;

  // Stage p0: decode the incoming word against the previous one
  assign vld_p0       = in_valid;
  assign parity_ok_p0 = ^din;
  assign seq_ok_p0    = have_prev && (din[6:0] != 7'd0) && (din[6:0] == prbs_next(prev));
  assign word_ok_p0   = parity_ok_p0 && seq_ok_p0;

  always_comb begin
    state_nxt = state;
    good_nxt  = good_run;
    bad_nxt   = bad_run;
    err_nxt   = 1'b0;
    par_inc   = 1'b0;
    seq_inc   = 1'b0;
    if (vld_p0) begin
      case (state)
        HUNT: begin
          good_nxt = word_ok_p0 ? good_run + 4'd1 : 4'd0;
          if (good_nxt == LOCK_N) begin
            state_nxt = LOCKED;
            bad_nxt   = 4'd0;
          end
        end
        LOCKED: begin
          // Errors are only meaningful once aligned, including the word that drops lock
          err_nxt = !word_ok_p0;
          par_inc = !parity_ok_p0;
          seq_inc = !seq_ok_p0;
          bad_nxt = word_ok_p0 ? 4'd0 : bad_run + 4'd1;
          if (bad_nxt == UNLOCK_N) begin
            state_nxt = HUNT;
            good_nxt  = 4'd0;
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  // Stage p1: registered state, history and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= HUNT;
      prev           <= 7'd0;
      have_prev      <= 1'b0;
      good_run       <= 4'd0;
      bad_run        <= 4'd0;
      err_pulse      <= 1'b0;
      parity_err_cnt <= '0;
      seq_err_cnt    <= '0;
    end else begin
      state     <= state_nxt;
      good_run  <= good_nxt;
      bad_run   <= bad_nxt;
      err_pulse <= err_nxt;
      if (vld_p0) begin
        prev      <= din[6:0];
        have_prev <= 1'b1;
      end
      if (clr) begin
        parity_err_cnt <= '0;
        seq_err_cnt    <= '0;
      end else begin
        if (par_inc) parity_err_cnt <= sat_inc(parity_err_cnt);
        if (seq_inc) seq_err_cnt    <= sat_inc(seq_err_cnt);
      end
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_prbs7_parity_checker.sv
// Bench for prbs7_parity_checker: directed vector table, hand-written corner sequences,
// and a randomized stream checked against a behavioural model.
module tb_prbs7_parity_checker;

  localparam int LOCK_COUNT   = 4;
  localparam int UNLOCK_COUNT = 3;
  localparam int CNT_W        = 4;
  localparam int CNT_MAX      = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [7:0]       din;
  logic             clr;
  logic             locked;
  logic             err_pulse;
  logic [CNT_W-1:0] parity_err_cnt;
  logic [CNT_W-1:0] seq_err_cnt;

  prbs7_parity_checker #(
    .LOCK_COUNT  (LOCK_COUNT),
    .UNLOCK_COUNT(UNLOCK_COUNT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .din           (din),
    .clr           (clr),
    .locked        (locked),
    .err_pulse     (err_pulse),
    .parity_err_cnt(parity_err_cnt),
    .seq_err_cnt   (seq_err_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       r;
    logic       v;
    logic [7:0] d;
    logic       c;
    int         el;
    int         ee;
    int         ep;
    int         es;
  } vec_t;
  vec_t tbl[$];

  // Behavioural reference: plain integers, following the word-by-word rules
  bit m_locked;
  bit m_err;
  bit m_have;
  int m_prev, m_good, m_bad, m_par, m_seq;

  function automatic int nxt7(input int p);
    return ((p * 2) % 128) + (((p / 64) + (p / 32)) % 2);
  endfunction

  function automatic logic [7:0] w(input logic [6:0] x);
    logic [7:0] r;
    r = {~^x, x};
    return r;
  endfunction

  task automatic model_step(input logic r, input logic v, input logic [7:0] d, input logic c);
    bit pok, sok;
    int dv;
    if (r) begin
      m_locked = 0; m_err = 0; m_have = 0; m_prev = 0;
      m_good = 0; m_bad = 0; m_par = 0; m_seq = 0;
      return;
    end
    m_err = 0;
    if (v) begin
      dv  = int'(d[6:0]);
      pok = ($countones(d) % 2) == 1;
      sok = m_have && dv != 0 && dv == nxt7(m_prev);
      if (!m_locked) begin
        m_good = (pok && sok) ? m_good + 1 : 0;
        if (m_good == LOCK_COUNT) begin m_locked = 1; m_bad = 0; end
      end else begin
        m_err = !(pok && sok);
        if (!pok) m_par = (m_par < CNT_MAX) ? m_par + 1 : CNT_MAX;
        if (!sok) m_seq = (m_seq < CNT_MAX) ? m_seq + 1 : CNT_MAX;
        m_bad = (pok && sok) ? 0 : m_bad + 1;
        if (m_bad == UNLOCK_COUNT) begin m_locked = 0; m_good = 0; end
      end
      m_prev = dv;
      m_have = 1;
    end
    if (c) begin m_par = 0; m_seq = 0; end
  endtask

  task automatic cmp(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [7:0] d, input logic c);
    @(negedge clk);
    rst = r; in_valid = v; din = d; clr = c;
    @(posedge clk);
    model_step(r, v, d, c);
    #1;
  endtask

  task automatic check_model(input string tag);
    cmp({tag, ".locked"}, int'(locked), int'(m_locked));
    cmp({tag, ".err_pulse"}, int'(err_pulse), int'(m_err));
    cmp({tag, ".parity_err_cnt"}, int'(parity_err_cnt), m_par);
    cmp({tag, ".seq_err_cnt"}, int'(seq_err_cnt), m_seq);
  endtask

  task automatic add(input logic r, input logic v, input logic [7:0] d, input logic c,
                     input int el, input int ee, input int ep, input int es);
    vec_t t;
    t.r = r; t.v = v; t.d = d; t.c = c;
    t.el = el; t.ee = ee; t.ep = ep; t.es = es;
    tbl.push_back(t);
  endtask

  initial begin
    logic [6:0] g;
    logic [7:0] d;
    logic       v, r, c;
    int         k;

    rst = 1'b1; in_valid = 1'b0; din = 8'h00; clr = 1'b0;

    // reset, lock after 1 + LOCK_COUNT words
    add(1, 0, 8'h00, 0, 0, 0, 0, 0);
    add(0, 1, w(7'h01), 0, 0, 0, 0, 0);
    add(0, 1, w(7'h02), 0, 0, 0, 0, 0);
    add(0, 1, w(7'h04), 0, 0, 0, 0, 0);
    add(0, 1, w(7'h08), 0, 0, 0, 0, 0);
    add(0, 1, w(7'h10), 0, 1, 0, 0, 0);
    add(0, 1, w(7'h20), 0, 1, 0, 0, 0);
    // parity error only
    add(0, 1, 8'h41, 0, 1, 1, 1, 0);
    add(0, 1, w(7'h03), 0, 1, 0, 1, 0);
    add(0, 1, w(7'h06), 0, 1, 0, 1, 0);
    add(0, 1, w(7'h0C), 0, 1, 0, 1, 0);
    // dropped word 0x18
    add(0, 1, w(7'h30), 0, 1, 1, 1, 1);
    add(0, 1, w(7'h61), 0, 1, 0, 1, 1);
    // three all-zero words unlock, the third still counted
    add(0, 1, 8'h80, 0, 1, 1, 1, 2);
    add(0, 1, 8'h80, 0, 1, 1, 1, 3);
    add(0, 1, 8'h80, 0, 0, 1, 1, 4);
    // relock: first word only re-anchors history
    add(0, 1, w(7'h42), 0, 0, 0, 1, 4);
    add(0, 1, w(7'h05), 0, 0, 0, 1, 4);
    add(0, 1, w(7'h0A), 0, 0, 0, 1, 4);
    add(0, 1, w(7'h14), 0, 0, 0, 1, 4);
    add(0, 1, w(7'h28), 0, 1, 0, 1, 4);
    // clear, then an idle cycle, then continue
    add(0, 1, w(7'h51), 1, 1, 0, 0, 0);
    add(0, 0, 8'h00, 0, 1, 0, 0, 0);
    add(0, 1, w(7'h23), 0, 1, 0, 0, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].c);
      cmp($sformatf("vec%0d.locked", i), int'(locked), tbl[i].el);
      cmp($sformatf("vec%0d.err_pulse", i), int'(err_pulse), tbl[i].ee);
      cmp($sformatf("vec%0d.parity_err_cnt", i), int'(parity_err_cnt), tbl[i].ep);
      cmp($sformatf("vec%0d.seq_err_cnt", i), int'(seq_err_cnt), tbl[i].es);
    end

    // saturation: parity-flipped words interleaved with good ones
    g = 7'h23;
    for (int i = 0; i < 20; i++) begin
      g = 7'(nxt7(int'(g)));
      drive(0, 1, w(g) ^ 8'h80, 0);
      cmp($sformatf("sat%0d.parity_err_cnt", i), int'(parity_err_cnt), (i + 1 > 15) ? 15 : i + 1);
      cmp($sformatf("sat%0d.locked", i), int'(locked), 1);
      g = 7'(nxt7(int'(g)));
      drive(0, 1, w(g), 0);
      check_model($sformatf("sat%0d", i));
    end

    // clr beats a simultaneous parity error; err_pulse unaffected
    g = 7'(nxt7(int'(g)));
    drive(0, 1, w(g) ^ 8'h80, 1);
    cmp("clr_bad.parity_err_cnt", int'(parity_err_cnt), 0);
    cmp("clr_bad.err_pulse", int'(err_pulse), 1);
    cmp("clr_bad.locked", int'(locked), 1);
    drive(0, 1, 8'h80, 0);
    cmp("pre_rst.seq_err_cnt", int'(seq_err_cnt), 1);

    // reset while locked with a nonzero counter
    drive(1, 1, w(7'h01), 0);
    cmp("mid_rst.locked", int'(locked), 0);
    cmp("mid_rst.err_pulse", int'(err_pulse), 0);
    cmp("mid_rst.parity_err_cnt", int'(parity_err_cnt), 0);
    cmp("mid_rst.seq_err_cnt", int'(seq_err_cnt), 0);

    // relock after reset, with gaps in between
    g = 7'h11;
    for (int i = 0; i < 5; i++) begin
      g = 7'(nxt7(int'(g)));
      drive(0, 1, w(g), 0);
      cmp($sformatf("relock%0d.locked", i), int'(locked), (i == 4) ? 1 : 0);
      drive(0, 0, 8'hFF, 0);
      cmp($sformatf("relock_gap%0d.locked", i), int'(locked), (i == 4) ? 1 : 0);
      cmp($sformatf("relock_gap%0d.err_pulse", i), int'(err_pulse), 0);
    end

    // randomized stream with gaps, errors, clears and rare resets
    for (int i = 0; i < 3000; i++) begin
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 499) == 0);
      c = ($urandom_range(0, 99) == 0);
      d = 8'($urandom);
      if (v) begin
        g = 7'(nxt7(int'(g)));
        d = w(g);
        k = int'($urandom_range(0, 11));
        case (k)
          0: d = d ^ 8'h80;
          1: d = 8'h80;
          2: begin g = 7'(nxt7(int'(g))); d = w(g); end
          3: d = 8'($urandom);
          default: ;
        endcase
      end
      drive(r, v, d, c);
      check_model($sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
